// File: rtl/dec138_sched_pkg.sv
// Shared types and constants for the round-robin SN74138 decoder scheduler.
package dec138_sched_pkg;

    localparam int CHANNELS = 8;
    localparam int SEL_W    = 3;

    // Enable triplet is {G1, G2a_n, G2b_n}; only 3'b100 enables the decoder.
    localparam logic [2:0] DEC_EN_ON  = 3'b100;
    localparam logic [2:0] DEC_EN_OFF = 3'b011;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        GRANT = 2'd2,
        GAP   = 2'd3
    } sched_state_t;

endpackage

// File: rtl/dec138_rr_sched_rr_pick8.sv
// Combinational round-robin pick: first set request at or after ptr, wrapping mod 8.
module rr_pick8
    import dec138_sched_pkg::*;
(
    input  logic [CHANNELS-1:0] req,
    input  logic [SEL_W-1:0]    ptr,
    output logic                found,
    output logic [SEL_W-1:0]    idx
);

    logic [SEL_W-1:0] cand;

    always_comb begin
        found = 1'b0;
        idx   = ptr;
        cand  = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            cand = ptr + SEL_W'(i);
            if (!found && req[cand]) begin
                found = 1'b1;
                idx   = cand;
            end
        end
    end

endmodule

// File: rtl/dec138_rr_sched.sv
// Round-robin scheduler sharing one 3-to-8 decoder between eight requesters,
// changing the select only while the decoder is disabled.
module dec138_rr_sched
    import dec138_sched_pkg::*;
#(
    parameter int HOLD_CYCLES = 4,
    parameter int GAP_CYCLES  = 1
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [CHANNELS-1:0] req,
    output logic [2:0]          dec_en,
    output logic [SEL_W-1:0]    dec_sel,
    output logic                grant_valid,
    output logic [SEL_W-1:0]    grant_id
);

    localparam int HW = $clog2(HOLD_CYCLES + 1);
    localparam int GW = $clog2(GAP_CYCLES + 1);
    localparam logic [HW-1:0] HOLD_MAX = HW'(HOLD_CYCLES);
    localparam logic [GW-1:0] GAP_MAX  = GW'(GAP_CYCLES);

    generate
        if (HOLD_CYCLES < 1) begin : g_bad_hold
            $error("HOLD_CYCLES must be at least 1");
        end
        if (GAP_CYCLES < 1) begin : g_bad_gap
            $error("GAP_CYCLES must be at least 1");
        end
    endgenerate

    sched_state_t     state;
    logic [SEL_W-1:0] ptr;
    logic [HW-1:0]    hold_cnt;
    logic [GW-1:0]    gap_cnt;
    logic             found;
    logic [SEL_W-1:0] winner;

    rr_pick8 u_pick (
        .req   (req),
        .ptr   (ptr),
        .found (found),
        .idx   (winner)
    );

    // Counters load 1 on state entry so they hold the number of the current cycle.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state       <= IDLE;
            ptr         <= '0;
            hold_cnt    <= '0;
            gap_cnt     <= '0;
            dec_en      <= DEC_EN_OFF;
            dec_sel     <= '0;
            grant_id    <= '0;
            grant_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (found) begin
                        dec_sel  <= winner;
                        grant_id <= winner;
                        state    <= SETUP;
                    end
                end
                SETUP: begin
                    dec_en      <= DEC_EN_ON;
                    grant_valid <= 1'b1;
                    hold_cnt    <= HW'(1);
                    state       <= GRANT;
                end
                GRANT: begin
                    if (hold_cnt == HOLD_MAX || !req[grant_id]) begin
                        dec_en      <= DEC_EN_OFF;
                        grant_valid <= 1'b0;
                        ptr         <= grant_id + SEL_W'(1);
                        gap_cnt     <= GW'(1);
                        state       <= GAP;
                    end else begin
                        hold_cnt <= hold_cnt + HW'(1);
                    end
                end
                GAP: begin
                    if (gap_cnt == GAP_MAX) begin
                        if (found) begin
                            dec_sel  <= winner;
                            grant_id <= winner;
                            state    <= SETUP;
                        end else begin
                            state <= IDLE;
                        end
                    end else begin
                        gap_cnt <= gap_cnt + GW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dec138_rr_sched.sv
// Directed bench for dec138_rr_sched (HOLD=4, GAP=1): a vector table plus
// hand-written multi-cycle sequences.
module tb_dec138_rr_sched;

    logic       clk;
    logic       reset_n;
    logic [7:0] req;
    logic [2:0] dec_en;
    logic [2:0] dec_sel;
    logic       grant_valid;
    logic [2:0] grant_id;

    int compared   = 0;
    int mismatched = 0;

    localparam logic [2:0] ON  = 3'b100;
    localparam logic [2:0] OFF = 3'b011;

    dec138_rr_sched #(.HOLD_CYCLES(4), .GAP_CYCLES(1)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .req         (req),
        .dec_en      (dec_en),
        .dec_sel     (dec_sel),
        .grant_valid (grant_valid),
        .grant_id    (grant_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rn;
        logic [7:0] rq;
        logic [2:0] en;
        logic [2:0] sel;
        logic       vld;
    } vec_t;

    vec_t vecs[16];

    task automatic applyStimulus(input logic rn, input logic [7:0] rq);
        @(negedge clk);
        reset_n = rn;
        req     = rq;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [2:0] en,
                               input logic [2:0] sel, input logic vld);
        compared++;
        if (dec_en !== en || dec_sel !== sel || grant_valid !== vld || grant_id !== sel) begin
            mismatched++;
            $display("[TB] FAIL %s: got en=%b sel=%0d vld=%b id=%0d, want en=%b sel=%0d vld=%b id=%0d",
                     name, dec_en, dec_sel, grant_valid, grant_id, en, sel, vld, sel);
        end
    endtask

    task automatic doReset();
        applyStimulus(1'b0, 8'h00);
        applyStimulus(1'b0, 8'h00);
    endtask

    // Four enabled cycles on ch, one GAP cycle, then SETUP with nxt.
    task automatic expectGrant(input string name, input logic [7:0] rq,
                               input logic [2:0] ch, input logic [2:0] nxt);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, rq);
            checkOutput({name, "_on"}, ON, ch, 1'b1);
        end
        applyStimulus(1'b1, rq);
        checkOutput({name, "_gap"}, OFF, ch, 1'b0);
        applyStimulus(1'b1, rq);
        checkOutput({name, "_setup"}, OFF, nxt, 1'b0);
    endtask

    initial begin
        reset_n = 1'b0;
        req     = 8'h00;

        // Reset with all requests, first grant 0, reset mid-grant, then lone requester 5.
        vecs[0]  = '{1'b0, 8'hFF, OFF, 3'd0, 1'b0};
        vecs[1]  = '{1'b0, 8'hFF, OFF, 3'd0, 1'b0};
        vecs[2]  = '{1'b1, 8'hFF, OFF, 3'd0, 1'b0};
        vecs[3]  = '{1'b1, 8'hFF, ON,  3'd0, 1'b1};
        vecs[4]  = '{1'b0, 8'hFF, OFF, 3'd0, 1'b0};
        vecs[5]  = '{1'b1, 8'h20, OFF, 3'd5, 1'b0};
        vecs[6]  = '{1'b1, 8'h20, ON,  3'd5, 1'b1};
        vecs[7]  = '{1'b1, 8'h20, ON,  3'd5, 1'b1};
        vecs[8]  = '{1'b1, 8'h20, ON,  3'd5, 1'b1};
        vecs[9]  = '{1'b1, 8'h20, ON,  3'd5, 1'b1};
        vecs[10] = '{1'b1, 8'h20, OFF, 3'd5, 1'b0};
        vecs[11] = '{1'b1, 8'h20, OFF, 3'd5, 1'b0};
        vecs[12] = '{1'b1, 8'h20, ON,  3'd5, 1'b1};
        vecs[13] = '{1'b1, 8'h20, ON,  3'd5, 1'b1};
        vecs[14] = '{1'b1, 8'h20, ON,  3'd5, 1'b1};
        vecs[15] = '{1'b1, 8'h20, ON,  3'd5, 1'b1};

        for (int i = 0; i < 16; i++) begin
            applyStimulus(vecs[i].rn, vecs[i].rq);
            checkOutput($sformatf("vec%0d", i), vecs[i].en, vecs[i].sel, vecs[i].vld);
        end

        // All channels requesting: order 0..7 then back to 0.
        doReset();
        applyStimulus(1'b1, 8'hFF);
        checkOutput("all_setup0", OFF, 3'd0, 1'b0);
        for (int k = 0; k < 8; k++) begin
            expectGrant($sformatf("all_g%0d", k), 8'hFF, 3'(k), 3'(k + 1));
        end
        applyStimulus(1'b1, 8'hFF);
        checkOutput("all_g0_again", ON, 3'd0, 1'b1);

        // Early release of channel 3 after two enabled cycles; next is 6.
        doReset();
        applyStimulus(1'b1, 8'h48);
        checkOutput("early_setup3", OFF, 3'd3, 1'b0);
        applyStimulus(1'b1, 8'h48);
        checkOutput("early_on1", ON, 3'd3, 1'b1);
        applyStimulus(1'b1, 8'h48);
        checkOutput("early_on2", ON, 3'd3, 1'b1);
        applyStimulus(1'b1, 8'h40);
        checkOutput("early_off", OFF, 3'd3, 1'b0);
        applyStimulus(1'b1, 8'h48);
        checkOutput("early_setup6", OFF, 3'd6, 1'b0);
        applyStimulus(1'b1, 8'h48);
        checkOutput("early_on6", ON, 3'd6, 1'b1);

        // Wrap: 0 -> 7 -> 0 with only channels 0 and 7 requesting.
        doReset();
        applyStimulus(1'b1, 8'h81);
        checkOutput("wrap_setup0", OFF, 3'd0, 1'b0);
        expectGrant("wrap_g0", 8'h81, 3'd0, 3'd7);
        expectGrant("wrap_g7", 8'h81, 3'd7, 3'd0);

        // Request dropped during SETUP still yields a single enabled cycle.
        doReset();
        applyStimulus(1'b1, 8'h04);
        checkOutput("min_setup2", OFF, 3'd2, 1'b0);
        applyStimulus(1'b1, 8'h00);
        checkOutput("min_on", ON, 3'd2, 1'b1);
        applyStimulus(1'b1, 8'h00);
        checkOutput("min_off", OFF, 3'd2, 1'b0);
        applyStimulus(1'b1, 8'h00);
        checkOutput("min_idle", OFF, 3'd2, 1'b0);

        // Reset mid-grant after ptr has moved to 6; req 0x41 distinguishes ptr 0 from ptr 6.
        doReset();
        applyStimulus(1'b1, 8'h20);
        checkOutput("rmg_setup5", OFF, 3'd5, 1'b0);
        expectGrant("rmg_g5", 8'h20, 3'd5, 3'd5);
        applyStimulus(1'b1, 8'h20);
        checkOutput("rmg_on", ON, 3'd5, 1'b1);
        applyStimulus(1'b0, 8'h20);
        checkOutput("rmg_reset", OFF, 3'd0, 1'b0);
        applyStimulus(1'b1, 8'h41);
        checkOutput("rmg_ptr0", OFF, 3'd0, 1'b0);
        applyStimulus(1'b1, 8'h41);
        checkOutput("rmg_on0", ON, 3'd0, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
